load_store_unit: RTL and testbench

Bridges the core's load/store requests to the byte-addressed data RAM port. The RAM port has a registered address latch (write_address strobe), a combinational 32-bit little-endian read, and a sized write on the shared inout bus. The unit sequences each access as address-latch then access, drives or releases the tri-state bus, and sign/zero-extends load data before returning it with a one-cycle response pulse.

---
 rtl/load_store_unit.sv | 136 +++++++++++++
 tb/tb_load_store_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: sequences core load/store requests onto the byte-addressed
// data RAM port as address-latch then access, owns the shared tri-state data
// bus only for the store access cycle, and returns sign/zero-extended load
// data with a one-cycle response pulse.
module load_store_unit #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_address,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic                  mem_write_address,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [1:0]            mem_data_size,
    inout  wire  [31:0]           mem_data
);

    typedef enum logic [1:0] {IDLE, ADDR, ACCESS, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    write_q, write_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0]   address_q, address_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    error_q, error_d;

    logic                    req_illegal;
    logic [31:0]             load_ext;
    logic                    drive_bus;
    logic                    unused_addr_hi;

    // The RAM only sees ADDR_WIDTH bits; the rest of the core address is dropped.
    assign unused_addr_hi = ^req_address[31:ADDR_WIDTH];

    // Reserved encodings, plus unsigned variants that make no sense for stores.
    assign req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                         (req_write && req_funct3[2]);

    // State and request/response registers; reset discards any in-flight request.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            write_q   <= 1'b0;
            funct3_q  <= 3'b000;
            address_q <= '0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            funct3_q  <= funct3_d;
            address_q <= address_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
        end
    end

    // Next-state: illegal requests skip the memory phases entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = req_illegal ? RESP : ADDR;
            ADDR:    state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Load extension of the combinational RAM read word.
    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{mem_data[7]}}, mem_data[7:0]};
            3'b100:  load_ext = {24'h0, mem_data[7:0]};
            3'b001:  load_ext = {{16{mem_data[15]}}, mem_data[15:0]};
            3'b101:  load_ext = {16'h0, mem_data[15:0]};
            default: load_ext = mem_data;
        endcase
    end

    // Request latch on acceptance; response registers only change when a new
    // response is produced so they hold their value between pulses.
    always_comb begin
        write_d   = write_q;
        funct3_d  = funct3_q;
        address_d = address_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        if (state_q == IDLE && req_valid) begin
            write_d   = req_write;
            funct3_d  = req_funct3;
            address_d = req_address[ADDR_WIDTH-1:0];
            wdata_d   = req_wdata;
            if (req_illegal) begin
                rdata_d = 32'h0;
                error_d = 1'b1;
            end
        end
        if (state_q == ACCESS) begin
            rdata_d = write_q ? 32'h0 : load_ext;
            error_d = 1'b0;
        end
    end

    // Outputs decoded from registered state and latched request only.
    always_comb begin
        req_ready         = (state_q == IDLE);
        resp_valid        = (state_q == RESP);
        mem_write_address = (state_q == ADDR);
        mem_read          = (state_q == ACCESS) && !write_q;
        mem_write         = (state_q == ACCESS) && write_q;
        drive_bus         = (state_q == ACCESS) && write_q;
        mem_data_size     = 2'b00;
        if (state_q == ACCESS)
            mem_data_size = funct3_q[1] ? 2'b11 : {1'b0, funct3_q[0]};
    end

    assign mem_address = address_q;
    assign resp_rdata  = rdata_q;
    assign resp_error  = error_q;
    assign mem_data    = drive_bus ? wdata_q : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-array RAM with address latch drives the
// bus on reads, while a transaction-level byte-array model predicts every
// response from the RISC-V load/store rules.
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        mem_write_address, mem_read, mem_write;
  logic [15:0] mem_address;
  logic [1:0]  mem_data_size;
  wire  [31:0] mem_data;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.ADDR_WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_address(req_address), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_write_address(mem_write_address), .mem_address(mem_address),
    .mem_read(mem_read), .mem_write(mem_write), .mem_data_size(mem_data_size),
    .mem_data(mem_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] pat(int i);
    return 8'((i * 29) + ((i >> 8) * 7) + 3);
  endfunction

  // ---------------- RAM: address latch, comb LE read, sized write ----------
  logic [7:0]  ram [0:65535];
  logic [15:0] ram_addr = 16'h0;
  logic        ram_init = 1'b0;
  logic [31:0] ram_rd;

  always @(posedge clock) begin
    if (!ram_init) begin
      for (int i = 0; i < 65536; i++) ram[i] <= pat(i);
      ram_init <= 1'b1;
    end else if (reset) begin
      ram_addr <= 16'h0;
    end else begin
      if (mem_write_address) ram_addr <= mem_address;
      if (mem_write) begin
        ram[ram_addr] <= mem_data[7:0];
        if (mem_data_size != 2'b00) ram[16'(ram_addr + 16'd1)] <= mem_data[15:8];
        if (mem_data_size == 2'b11) begin
          ram[16'(ram_addr + 16'd2)] <= mem_data[23:16];
          ram[16'(ram_addr + 16'd3)] <= mem_data[31:24];
        end
      end
    end
  end

  assign ram_rd = {ram[16'(ram_addr + 16'd3)], ram[16'(ram_addr + 16'd2)],
                   ram[16'(ram_addr + 16'd1)], ram[ram_addr]};
  assign mem_data = mem_read ? ram_rd : 32'hzzzz_zzzz;

  // ---------------- reference model ---------------------------------------
  logic [7:0]  ref_mem [0:65535];
  logic [31:0] last_rdata;

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [15:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[16'(a + i)];
    case (f3)
      3'd0:    return int'($signed(w[7:0]));
      3'd4:    return int'(w[7:0]);
      3'd1:    return int'($signed(w[15:0]));
      3'd5:    return int'(w[15:0]);
      default: return w;
    endcase
  endfunction

  function automatic int store_bytes(logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus ownership must never overlap a read.
  always @(negedge clock) begin
    if (!reset && ram_init) chk("rd_wr_overlap", {31'h0, mem_read & mem_write}, 32'h0);
  end

  // One full request: accept in IDLE, then track each cycle to the response.
  task automatic txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input bit hold);
    logic [15:0] a;
    logic        illegal;
    logic [31:0] exp_rd;
    int          n;
    a       = addr[15:0];
    illegal = (f3 == 3'd3) || (f3 >= 3'd6) || (wr && (f3 == 3'd4 || f3 == 3'd5));
    exp_rd  = (illegal || wr) ? 32'h0 : ref_load(f3, a);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_address = addr; req_wdata = wd;
    @(negedge clock);
    chk("accept_ready", req_ready, 1);
    chk("idle_resp_valid", resp_valid, 0);
    chk("rdata_hold", resp_rdata, last_rdata);
    chk("idle_strobes", {mem_write_address, mem_read, mem_write}, 0);
    @(posedge clock); #1;
    if (!hold) req_valid = 1'b0;
    if (illegal) begin
      @(negedge clock);
      chk("err_resp_valid", resp_valid, 1);
      chk("err_resp_error", resp_error, 1);
      chk("err_rdata", resp_rdata, 0);
      chk("err_ready", req_ready, 0);
      chk("err_strobes", {mem_write_address, mem_read, mem_write}, 0);
    end else begin
      @(negedge clock);
      chk("addr_strobe", mem_write_address, 1);
      chk("addr_value", mem_address, a);
      chk("addr_ready", req_ready, 0);
      chk("addr_resp_valid", resp_valid, 0);
      chk("addr_rw", {mem_read, mem_write}, 0);
      @(posedge clock);
      @(negedge clock);
      chk("acc_read", mem_read, !wr);
      chk("acc_write", mem_write, wr);
      chk("acc_latch", mem_write_address, 0);
      chk("acc_ready", req_ready, 0);
      chk("acc_resp_valid", resp_valid, 0);
      n = store_bytes(f3);
      if (wr) begin
        chk("acc_size", mem_data_size, (n == 4) ? 2'b11 : 2'(n - 1));
        chk("acc_bus_data", mem_data, wd);
      end
      @(posedge clock);
      @(negedge clock);
      chk("resp_valid", resp_valid, 1);
      chk("resp_rdata", resp_rdata, exp_rd);
      chk("resp_error", resp_error, 0);
      chk("resp_ready", req_ready, 0);
      chk("resp_strobes", {mem_write_address, mem_read, mem_write}, 0);
      if (wr) for (int i = 0; i < n; i++) ref_mem[16'(a + i)] = wd[8*i +: 8];
    end
    last_rdata = exp_rd;
    @(posedge clock); #1;
  endtask

  initial begin
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] ad, wd;
    bit          h;
    for (int i = 0; i < 65536; i++) ref_mem[i] = pat(i);
    last_rdata = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_address = 32'h0; req_wdata = 32'h0;
    @(posedge clock); @(posedge clock);
    @(negedge clock);
    chk("rst_ready", req_ready, 1);
    chk("rst_resp", {resp_valid, resp_error}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_strobes", {mem_write_address, mem_read, mem_write}, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_size", mem_data_size, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Directed cases.
    txn(1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 0);
    txn(0, 3'd2, 32'h0000_0100, 32'h0, 0);
    txn(1, 3'd0, 32'h0000_0200, 32'h0000_0080, 0);
    txn(0, 3'd0, 32'h0000_0200, 32'h0, 0);
    txn(0, 3'd4, 32'h0000_0200, 32'h0, 0);
    txn(1, 3'd2, 32'h0000_0100, 32'h0, 0);
    txn(1, 3'd1, 32'h0000_0101, 32'h0000_A5F0, 0);
    txn(0, 3'd2, 32'h0000_0100, 32'h0, 0);
    txn(0, 3'd5, 32'h0000_0101, 32'h0, 0);
    txn(0, 3'd1, 32'h0000_0101, 32'h0, 0);
    txn(0, 3'd3, 32'h0000_0100, 32'h0, 0);
    txn(1, 3'd4, 32'h0000_0100, 32'h1234_5678, 0);
    txn(0, 3'd2, 32'h0000_0100, 32'h0, 0);

    // Randomized, with req_valid often held across back-to-back requests.
    for (int k = 0; k < 60; k++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else begin
        case ($urandom_range(0, wr ? 2 : 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
      end
      ad = ($urandom() & 32'hFFFF_0000) | 32'(16'h0300 + 16'($urandom_range(0, 63)));
      wd = $urandom();
      h  = 1'($urandom_range(0, 1));
      txn(wr, f3, ad, wd, h);
    end
    req_valid = 1'b0;
    @(posedge clock); #1;

    // Reset in the middle of a store access.
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
    req_address = 32'h0001_0004; req_wdata = ~ref_load(3'd2, 16'h0004);
    @(negedge clock);
    chk("rst_test_ready", req_ready, 1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    chk("rst_test_trunc", mem_address, 16'h0004);
    chk("rst_test_latch", mem_write_address, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("rst_test_acc_write", mem_write, 1);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_test_strobes", {mem_write_address, mem_read, mem_write}, 0);
    chk("rst_test_no_resp", resp_valid, 0);
    chk("rst_test_ready_after", req_ready, 1);
    @(posedge clock);
    @(negedge clock);
    chk("rst_test_no_resp2", resp_valid, 0);
    @(posedge clock); #1;
    last_rdata = 32'h0;
    txn(0, 3'd2, 32'h0000_0004, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
